// File: rtl/pc_thread_sched_if.sv
// Control bundle between the thread scheduler and its neighbours:
// fetch/branch inputs on one side, PC-file read/write controls on the other.
interface pc_thread_sched_if;
  logic [1:0] en_mask;
  logic       pipe_stall;
  logic       wait_set;
  logic [1:0] wait_clr;
  logic       branch_valid;
  logic       branch_ts;
  logic       r_ts;
  logic       w_ts;
  logic       ws;
  logic       hold;
  logic       sel_branch;
  logic       fetch_valid;
  logic       idle;

  modport master (
    input  en_mask, pipe_stall, wait_set, wait_clr, branch_valid, branch_ts,
    output r_ts, w_ts, ws, hold, sel_branch, fetch_valid, idle
  );

  modport slave (
    output en_mask, pipe_stall, wait_set, wait_clr, branch_valid, branch_ts,
    input  r_ts, w_ts, ws, hold, sel_branch, fetch_valid, idle
  );
endinterface

// File: rtl/pc_thread_sched.sv
// Two-thread round-robin PC scheduler: picks the fetch thread, merges branch
// redirects and sequential advances onto the PC file's single write port.
module pc_thread_sched #(
  parameter int unsigned QUANTUM = 4
) (
  input  logic               clk,
  input  logic               a_rst,
  pc_thread_sched_if.master  bus
);

  typedef enum logic [1:0] {BOOT, RUN, SWITCH, IDLE} state_t;

  localparam logic [7:0] LAST = 8'(QUANTUM - 1);

  state_t     state_reg, state_next;
  logic       cur_ts_reg, cur_ts_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [1:0] waiting_reg, waiting_next;

  logic [1:0] runnable;
  logic       advance;
  logic       other_run;
  logic       cur_stays;
  logic       leaving;

  assign advance   = (state_reg == RUN) & ~bus.pipe_stall & ~bus.branch_valid;
  assign other_run = runnable[~cur_ts_reg];
  assign cur_stays = runnable[cur_ts_reg] & ~bus.wait_set;
  assign leaving   = bus.wait_set | ~bus.en_mask[cur_ts_reg] |
                     ((cnt_reg == LAST) & other_run);

  // A set and a clear on the same thread in one cycle leaves it blocked.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_thr
      assign runnable[gi]     = bus.en_mask[gi] & ~waiting_reg[gi];
      assign waiting_next[gi] = (advance & bus.wait_set & (cur_ts_reg == 1'(gi))) |
                                (waiting_reg[gi] & ~bus.wait_clr[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_reg   <= BOOT;
      cur_ts_reg  <= 1'b0;
      cnt_reg     <= 8'd0;
      waiting_reg <= 2'b00;
    end else begin
      state_reg   <= state_next;
      cur_ts_reg  <= cur_ts_next;
      cnt_reg     <= cnt_next;
      waiting_reg <= waiting_next;
    end
  end

  // Entering SWITCH is where the thread id toggles, so the bubble already
  // presents the incoming thread on r_ts.
  always_comb begin
    state_next  = state_reg;
    cur_ts_next = cur_ts_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      BOOT: begin
        cnt_next = 8'd0;
        if (runnable[0]) begin
          state_next = RUN;
        end else if (runnable[1]) begin
          state_next  = SWITCH;
          cur_ts_next = ~cur_ts_reg;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (advance) begin
          if (leaving) begin
            cnt_next = 8'd0;
            if (other_run) begin
              state_next  = SWITCH;
              cur_ts_next = ~cur_ts_reg;
            end else if (!cur_stays) begin
              state_next = IDLE;
            end
          end else begin
            cnt_next = (cnt_reg == LAST) ? 8'd0 : cnt_reg + 8'd1;
          end
        end
      end
      SWITCH: state_next = RUN;
      IDLE: begin
        if (other_run) begin
          state_next  = SWITCH;
          cur_ts_next = ~cur_ts_reg;
          cnt_next    = 8'd0;
        end else if (runnable[cur_ts_reg]) begin
          state_next = RUN;
          cnt_next   = 8'd0;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  logic ws_c, w_ts_c, sel_c;

  always_comb begin
    ws_c   = 1'b0;
    w_ts_c = cur_ts_reg;
    sel_c  = 1'b0;
    if (bus.branch_valid && state_reg != BOOT) begin
      ws_c   = 1'b1;
      w_ts_c = bus.branch_ts;
      sel_c  = 1'b1;
    end else if (state_reg == RUN && !bus.pipe_stall) begin
      ws_c = 1'b1;
    end
  end

  assign bus.r_ts        = cur_ts_reg;
  assign bus.ws          = ws_c;
  assign bus.w_ts        = w_ts_c;
  assign bus.sel_branch  = sel_c;
  assign bus.hold        = ~ws_c;
  assign bus.fetch_valid = advance;
  assign bus.idle        = (state_reg == IDLE);

endmodule

// File: tb/tb_pc_thread_sched.sv
// Directed bench for pc_thread_sched (QUANTUM=4); outputs are packed as
// {r_ts, ws, w_ts, sel_branch, fetch_valid, idle, hold}.
module tb_pc_thread_sched;

  logic clk;
  logic a_rst;
  int   checks;
  int   failures;

  pc_thread_sched_if bus ();

  pc_thread_sched #(.QUANTUM(4)) dut (
    .clk   (clk),
    .a_rst (a_rst),
    .bus   (bus)
  );

  logic [6:0] obs;
  assign obs = {bus.r_ts, bus.ws, bus.w_ts, bus.sel_branch,
                bus.fetch_valid, bus.idle, bus.hold};

  localparam logic [6:0] BOOTV = 7'b0000001;
  localparam logic [6:0] RUN0  = 7'b0100100;
  localparam logic [6:0] RUN1  = 7'b1110100;
  localparam logic [6:0] SW1   = 7'b1010001;
  localparam logic [6:0] SW0   = 7'b0000001;
  localparam logic [6:0] IDLE0 = 7'b0000011;
  localparam logic [6:0] IDLE1 = 7'b1010011;
  localparam logic [6:0] BR01  = 7'b0111000;
  localparam logic [6:0] BRSW  = 7'b1101000;
  localparam logic [6:0] STL0  = 7'b0000001;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its BOOT cycle, just after the release of reset.
  task automatic start(input logic [1:0] en);
    a_rst            = 1'b0;
    bus.en_mask      = en;
    bus.pipe_stall   = 1'b0;
    bus.wait_set     = 1'b0;
    bus.wait_clr     = 2'b00;
    bus.branch_valid = 1'b0;
    bus.branch_ts    = 1'b0;
    tick();
    a_rst = 1'b1;
  endtask

  task automatic test_reset;
    a_rst            = 1'b0;
    bus.en_mask      = 2'b11;
    bus.pipe_stall   = 1'b0;
    bus.wait_set     = 1'b0;
    bus.wait_clr     = 2'b00;
    bus.branch_valid = 1'b1;
    bus.branch_ts    = 1'b1;
    #2;
    checks++;
    if (obs !== BOOTV) begin
      failures++;
      $display("FAIL reset_out: got %b want %b", obs, BOOTV);
    end
    tick();
    a_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== BOOTV) begin
      failures++;
      $display("FAIL boot_ignores_branch: got %b want %b", obs, BOOTV);
    end
    bus.branch_valid = 1'b0;
    bus.branch_ts    = 1'b0;
    tick();
  endtask

  task automatic test_round_robin;
    logic [6:0] exp;
    start(2'b11);
    @(negedge clk);
    checks++;
    if (obs !== BOOTV) begin
      failures++;
      $display("FAIL rr_boot: got %b want %b", obs, BOOTV);
    end
    tick();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        exp = (r == 0) ? RUN0 : RUN1;
        @(negedge clk);
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL rr_run r%0d c%0d: got %b want %b", r, i, obs, exp);
        end
        tick();
      end
      exp = (r == 0) ? SW1 : SW0;
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL rr_switch r%0d: got %b want %b", r, obs, exp);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (obs !== RUN0) begin
      failures++;
      $display("FAIL rr_back_to_t0: got %b want %b", obs, RUN0);
    end
    tick();
  endtask

  task automatic test_single_thread;
    start(2'b01);
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== RUN0) begin
        failures++;
        $display("FAIL single_run c%0d: got %b want %b", i, obs, RUN0);
      end
      tick();
    end
  endtask

  task automatic test_wait_switch;
    logic [6:0] seq_exp [7];
    seq_exp = '{RUN0, RUN0, SW1, RUN1, RUN1, IDLE1, SW0};
    start(2'b11);
    tick();
    for (int i = 0; i < 7; i++) begin
      bus.wait_set = (i == 1) || (i == 4);
      bus.wait_clr = (i == 4) ? 2'b01 : 2'b00;
      @(negedge clk);
      checks++;
      if (obs !== seq_exp[i]) begin
        failures++;
        $display("FAIL wait_switch c%0d: got %b want %b", i, obs, seq_exp[i]);
      end
      tick();
    end
    bus.wait_set = 1'b0;
    bus.wait_clr = 2'b00;
    @(negedge clk);
    checks++;
    if (obs !== RUN0) begin
      failures++;
      $display("FAIL wait_switch_resume: got %b want %b", obs, RUN0);
    end
    tick();
  endtask

  task automatic test_idle_wake;
    logic [6:0] seq_exp [9];
    seq_exp = '{SW1, RUN1, SW0, RUN0, IDLE0, IDLE0, IDLE0, IDLE0, SW1};
    start(2'b11);
    tick();
    repeat (4) tick();
    for (int i = 0; i < 9; i++) begin
      bus.wait_set = (i == 1) || (i == 3);
      bus.wait_clr = (i == 3) ? 2'b01 : ((i == 6) ? 2'b10 : 2'b00);
      @(negedge clk);
      checks++;
      if (obs !== seq_exp[i]) begin
        failures++;
        $display("FAIL idle_wake c%0d: got %b want %b", i, obs, seq_exp[i]);
      end
      tick();
    end
    bus.wait_set = 1'b0;
    bus.wait_clr = 2'b00;
    @(negedge clk);
    checks++;
    if (obs !== RUN1) begin
      failures++;
      $display("FAIL idle_wake_run_t1: got %b want %b", obs, RUN1);
    end
    tick();
  endtask

  task automatic test_branch;
    logic [6:0] seq_exp [7];
    seq_exp = '{RUN0, RUN0, BR01, RUN0, RUN0, BRSW, RUN1};
    start(2'b11);
    tick();
    for (int i = 0; i < 7; i++) begin
      bus.branch_valid = (i == 2) || (i == 5);
      bus.branch_ts    = (i == 2);
      @(negedge clk);
      checks++;
      if (obs !== seq_exp[i]) begin
        failures++;
        $display("FAIL branch c%0d: got %b want %b", i, obs, seq_exp[i]);
      end
      tick();
    end
    bus.branch_valid = 1'b0;
    bus.branch_ts    = 1'b0;
  endtask

  task automatic test_stall;
    logic [6:0] seq_exp [8];
    seq_exp = '{RUN0, STL0, STL0, STL0, RUN0, RUN0, RUN0, SW1};
    start(2'b11);
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.pipe_stall = (i >= 1) && (i <= 3);
      @(negedge clk);
      checks++;
      if (obs !== seq_exp[i]) begin
        failures++;
        $display("FAIL stall c%0d: got %b want %b", i, obs, seq_exp[i]);
      end
      tick();
    end
    bus.pipe_stall = 1'b0;
  endtask

  task automatic test_reset_mid_switch;
    start(2'b11);
    tick();
    bus.wait_set = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== RUN0) begin
      failures++;
      $display("FAIL rst_pre_run: got %b want %b", obs, RUN0);
    end
    tick();
    bus.wait_set = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== SW1) begin
      failures++;
      $display("FAIL rst_in_switch: got %b want %b", obs, SW1);
    end
    #1;
    a_rst = 1'b0;
    #1;
    checks++;
    if (obs !== BOOTV) begin
      failures++;
      $display("FAIL rst_async: got %b want %b", obs, BOOTV);
    end
    tick();
    a_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== BOOTV) begin
      failures++;
      $display("FAIL rst_boot: got %b want %b", obs, BOOTV);
    end
    tick();
    @(negedge clk);
    checks++;
    if (obs !== RUN0) begin
      failures++;
      $display("FAIL rst_waiting_cleared: got %b want %b", obs, RUN0);
    end
    tick();
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    a_rst            = 1'b0;
    bus.en_mask      = 2'b00;
    bus.pipe_stall   = 1'b0;
    bus.wait_set     = 1'b0;
    bus.wait_clr     = 2'b00;
    bus.branch_valid = 1'b0;
    bus.branch_ts    = 1'b0;
    test_reset();
    test_round_robin();
    test_single_thread();
    test_wait_switch();
    test_idle_wake();
    test_branch();
    test_stall();
    test_reset_mid_switch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
